// File: rtl/serial_adder_if.sv
// serial_adder_if
// Request/result bundle for the bit-serial adder/subtractor.
//   i_start, i_sub, i_a, i_b, i_carry_in : request side (driven by master)
//   o_busy, o_done, o_s, o_carry_out, o_overflow : result side (driven by slave)
// Modports: master (requester), slave (the adder itself).
interface serial_adder_if #(
    parameter int W = 8
);
    logic         i_start;
    logic         i_sub;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_carry_in;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_s;
    logic         o_carry_out;
    logic         o_overflow;

    modport master (
        output i_start, i_sub, i_a, i_b, i_carry_in,
        input  o_busy, o_done, o_s, o_carry_out, o_overflow
    );

    modport slave (
        input  i_start, i_sub, i_a, i_b, i_carry_in,
        output o_busy, o_done, o_s, o_carry_out, o_overflow
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial adder/subtractor: W-bit operands are processed LSB first, one
// bit per clock, through a single full-adder slice and a carry register.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : serial_adder_if.slave (start/sub/operands in, busy/done/result out)
// Latency: o_done rises in the cycle after the W-th edge following the accept
// edge. Results are held until the next o_done.
module serial_adder #(
    parameter int W = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_reg;
    logic [W-1:0]  a_reg;      // operand A; also collects the sum from the MSB end
    logic [W-1:0]  b_reg;      // operand B (already inverted for subtraction)
    logic          carry_reg;
    logic [CW-1:0] cnt_reg;
    logic [W-1:0]  s_reg;
    logic          cout_reg;
    logic          ovf_reg;
    logic          done_reg;
    logic          busy_reg;

    // One full-adder slice on the current LSBs.
    logic         sum_bit;
    logic         carry_next;
    logic [W:0]   a_ext;
    logic [W:0]   b_ext;
    logic [W-1:0] a_next;
    logic [W-1:0] b_next;
    logic         last_bit;

    assign sum_bit    = a_reg[0] ^ b_reg[0] ^ carry_reg;
    assign carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);

    // A shifts right and the fresh sum bit enters at its MSB, so after W steps
    // the A register holds the complete sum. The extended vectors keep the
    // shift expressions legal for W == 1.
    assign a_ext    = {sum_bit, a_reg};
    assign b_ext    = {1'b0, b_reg};
    assign a_next   = a_ext[W:1];
    assign b_next   = b_ext[W:1];
    assign last_bit = (cnt_reg == CW'(W - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            s_reg     <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (bus.i_start) begin
                        // Subtraction is a + ~b + 1; a borrow-in cancels the +1.
                        a_reg     <= bus.i_a;
                        b_reg     <= bus.i_b ^ {W{bus.i_sub}};
                        carry_reg <= bus.i_carry_in ^ bus.i_sub;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ADD;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                ADD: begin
                    a_reg     <= a_next;
                    b_reg     <= b_next;
                    carry_reg <= carry_next;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (last_bit) begin
                        // carry_reg is the carry into the MSB at this point.
                        s_reg     <= a_next;
                        cout_reg  <= carry_next;
                        ovf_reg   <= carry_reg ^ carry_next;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy      = busy_reg;
    assign bus.o_done      = done_reg;
    assign bus.o_s         = s_reg;
    assign bus.o_carry_out = cout_reg;
    assign bus.o_overflow  = ovf_reg;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
// Directed bench for serial_adder: one W=1 instance (full-adder truth table)
// and one W=8 instance (add, sub, overflow, ignored start, back-to-back, reset).
module tb_serial_adder;
    logic i_clk;
    logic i_rst_n;
    int   total;
    int   bad;
    logic [7:0] last_s;   // expected held result of the W=8 instance

    serial_adder_if #(.W(1)) if1 ();
    serial_adder_if #(.W(8)) if8 ();

    serial_adder #(.W(1)) dut1 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(if1));
    serial_adder #(.W(8)) dut8 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(if8));

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Runs one W=8 op starting at a negedge; returns at the negedge of the
    // o_done cycle with i_start low.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                           input logic cin, input logic [7:0] exp_s, input logic exp_c,
                           input logic exp_o, input string name);
        if8.i_start = 1'b1; if8.i_a = a; if8.i_b = b; if8.i_sub = sub; if8.i_carry_in = cin;
        @(posedge i_clk);
        @(negedge i_clk);
        if8.i_start = 1'b0;
        if8.i_a = ~a; if8.i_b = ~b; if8.i_sub = ~sub; if8.i_carry_in = ~cin;
        for (int k = 1; k <= 8; k++) begin
            total++;
            if (if8.o_busy !== 1'b1 || if8.o_done !== 1'b0 || if8.o_s !== last_s) begin
                bad++;
                $display("FAIL %s_inflight cyc=%0d busy=%b done=%b s=%h required busy=1 done=0 s=%h",
                         name, k, if8.o_busy, if8.o_done, if8.o_s, last_s);
            end
            @(posedge i_clk);
            @(negedge i_clk);
        end
        total++;
        if (if8.o_done !== 1'b1 || if8.o_busy !== 1'b0 || if8.o_s !== exp_s ||
            if8.o_carry_out !== exp_c || if8.o_overflow !== exp_o) begin
            bad++;
            $display("FAIL %s done=%b busy=%b s=%h c=%b v=%b required done=1 busy=0 s=%h c=%b v=%b",
                     name, if8.o_done, if8.o_busy, if8.o_s, if8.o_carry_out, if8.o_overflow,
                     exp_s, exp_c, exp_o);
        end
        $display("op %s a=%h b=%h sub=%b cin=%b -> s=%h c=%b v=%b",
                 name, a, b, sub, cin, if8.o_s, if8.o_carry_out, if8.o_overflow);
        last_s = exp_s;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        if1.i_start = 0; if1.i_sub = 0; if1.i_a = 0; if1.i_b = 0; if1.i_carry_in = 0;
        if8.i_start = 0; if8.i_sub = 0; if8.i_a = 0; if8.i_b = 0; if8.i_carry_in = 0;
        last_s = 8'h00;
        repeat (2) @(negedge i_clk);
        total++;
        if (if8.o_busy !== 1'b0 || if8.o_done !== 1'b0 || if8.o_s !== 8'h00 ||
            if8.o_carry_out !== 1'b0 || if8.o_overflow !== 1'b0 ||
            if1.o_busy !== 1'b0 || if1.o_done !== 1'b0 || if1.o_s !== 1'b0) begin
            bad++;
            $display("FAIL reset busy=%b done=%b s=%h c=%b v=%b required all zero",
                     if8.o_busy, if8.o_done, if8.o_s, if8.o_carry_out, if8.o_overflow);
        end
        $display("reset checked");
        i_rst_n = 1'b1;
    endtask

    task automatic test_full_adder();
        logic [2:0] v;
        logic [1:0] exp;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
            if1.i_start = 1'b1; if1.i_a = v[2]; if1.i_b = v[1]; if1.i_carry_in = v[0]; if1.i_sub = 1'b0;
            @(posedge i_clk);
            @(negedge i_clk);
            if1.i_start = 1'b0;
            total++;
            if (if1.o_busy !== 1'b1 || if1.o_done !== 1'b0) begin
                bad++;
                $display("FAIL fa_busy%0d busy=%b done=%b required busy=1 done=0", i, if1.o_busy, if1.o_done);
            end
            @(posedge i_clk);
            @(negedge i_clk);
            total++;
            if (if1.o_done !== 1'b1 || {if1.o_carry_out, if1.o_s} !== exp ||
                if1.o_overflow !== (v[0] ^ exp[1])) begin
                bad++;
                $display("FAIL fa%0d done=%b cs=%b%b v=%b required done=1 cs=%b v=%b",
                         i, if1.o_done, if1.o_carry_out, if1.o_s, if1.o_overflow, exp, v[0] ^ exp[1]);
            end
            $display("fa a=%b b=%b cin=%b -> c=%b s=%b", v[2], v[1], v[0], if1.o_carry_out, if1.o_s);
            @(negedge i_clk);
        end
    endtask

    task automatic test_add();
        run_op8(8'd100, 8'd27, 1'b0, 1'b0, 8'd127, 1'b0, 1'b0, "add_100_27");
        @(negedge i_clk);
        run_op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
        @(negedge i_clk);
        run_op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
        @(negedge i_clk);
        run_op8(8'h10, 8'h20, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0, "add_cin");
        @(negedge i_clk);
    endtask

    task automatic test_sub();
        run_op8(8'd5, 8'd7, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, "sub_5_7");
        @(negedge i_clk);
        run_op8(8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, "sub_80_01");
        @(negedge i_clk);
        run_op8(8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0, "sub_borrow");
        @(negedge i_clk);
    endtask

    task automatic test_back_to_back();
        // Start op, pulse i_start 3 cycles in with other operands.
        if8.i_start = 1'b1; if8.i_a = 8'd100; if8.i_b = 8'd27; if8.i_sub = 1'b0; if8.i_carry_in = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        if8.i_start = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        if8.i_start = 1'b1; if8.i_a = 8'h55; if8.i_b = 8'h33; if8.i_sub = 1'b1;
        @(negedge i_clk);
        if8.i_start = 1'b0;
        repeat (5) @(negedge i_clk);
        total++;
        if (if8.o_done !== 1'b1 || if8.o_s !== 8'd127 || if8.o_carry_out !== 1'b0 || if8.o_overflow !== 1'b0) begin
            bad++;
            $display("FAIL ignore_start done=%b s=%h c=%b v=%b required done=1 s=7f c=0 v=0",
                     if8.o_done, if8.o_s, if8.o_carry_out, if8.o_overflow);
        end
        $display("op ignore_start -> s=%h", if8.o_s);
        last_s = 8'd127;
        // Now in the o_done cycle: request the next op back-to-back.
        run_op8(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, "back_to_back");
        @(negedge i_clk);
    endtask

    task automatic test_async_reset();
        if8.i_start = 1'b1; if8.i_a = 8'h55; if8.i_b = 8'h11; if8.i_sub = 1'b0; if8.i_carry_in = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        if8.i_start = 1'b0;
        repeat (4) @(posedge i_clk);   // bits 0..3 processed
        #2;
        i_rst_n = 1'b0;
        #1;
        total++;
        if (if8.o_busy !== 1'b0 || if8.o_done !== 1'b0 || if8.o_s !== 8'h00 ||
            if8.o_carry_out !== 1'b0 || if8.o_overflow !== 1'b0) begin
            bad++;
            $display("FAIL async_reset busy=%b done=%b s=%h c=%b v=%b required all zero",
                     if8.o_busy, if8.o_done, if8.o_s, if8.o_carry_out, if8.o_overflow);
        end
        $display("async reset mid-op -> busy=%b s=%h", if8.o_busy, if8.o_s);
        last_s = 8'h00;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            total++;
            if (if8.o_done !== 1'b0 || if8.o_busy !== 1'b0) begin
                bad++;
                $display("FAIL no_done_after_reset cyc=%0d done=%b busy=%b required 0 0", k, if8.o_done, if8.o_busy);
            end
        end
        run_op8(8'h0F, 8'hF1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "after_reset");
        @(negedge i_clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        @(negedge i_clk);
        test_full_adder();
        test_add();
        test_sub();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
